// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage that sits directly in front of a combinational
// instruction memory. It owns the PC, presents it as the memory address, and
// captures the returned word into the IF/ID register. It handles decode
// back-pressure, hazard stalls, branch/jump redirects (with flush), and halt
// on a syscall word.
//
// Handshake (IF/ID output): a transfer happens on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_instr and out_pc stay stable. out_valid never depends on out_ready
// combinationally.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   im_addr        out  32  instruction memory address (= pc)
//   im_data        in   32  instruction word for im_addr, same cycle
//   stall          in   1   hazard stall: no new fetch this cycle
//   redirect_valid in   1   taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc    in   32  redirect target byte address
//   out_valid      out  1   IF/ID holds a valid instruction
//   out_ready      in   1   decode accepts IF/ID contents this cycle
//   out_instr      out  32  fetched instruction
//   out_pc         out  32  byte address of out_instr
//   halted         out  1   high while in S_HALT
//   fetch_cnt      out  16  instructions fetched into IF/ID, wraps at 2^16
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd8,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic        fetch_en;

    // A fetch needs the RUN state, no stall, no redirect, and room in IF/ID
    // (empty, or being drained by decode this same cycle).
    assign fetch_en = (state_q == S_RUN) && !stall && !redirect_valid &&
                      (!out_valid_q || out_ready);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end else if (fetch_en && (im_data == HALT_WORD)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // PC and IF/ID register next values
    // ------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fetch_cnt_d = fetch_cnt_q;

        if (redirect_valid) begin
            // Flush wins over everything, in every state. The discarded
            // instruction stays counted in fetch_cnt.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
        end else if (fetch_en) begin
            out_instr_d = im_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
            fetch_cnt_q <= 16'h0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign im_addr   = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign fetch_cnt = fetch_cnt_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] HALT_WORD = 32'h0000_000C;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [15:0] fetch_cnt;

    int tests_run;
    int tests_failed;

    // memory model: pc-tagged words, optional halt word at one address
    logic        halt_en;
    logic [31:0] halt_at;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    assign im_data = (halt_en && im_addr == halt_at) ? HALT_WORD : tag(im_addr);

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_data        (im_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // check the whole visible IF/ID + pc picture
    task automatic chk_all(input string name, input logic ov, input logic [31:0] opc,
                           input logic [31:0] ia, input logic [15:0] cnt);
        chk({name, ".out_valid"}, {31'h0, out_valid}, {31'h0, ov});
        if (ov) begin
            chk({name, ".out_pc"}, out_pc, opc);
            chk({name, ".out_instr"}, out_instr, tag(opc));
        end
        chk({name, ".im_addr"}, im_addr, ia);
        chk({name, ".fetch_cnt"}, {16'h0, fetch_cnt}, {16'h0, cnt});
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        halt_en        = 1'b0;
        halt_at        = 32'h0;

        // reset values
        tick();
        tick();
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.out_instr", out_instr, 32'h0);
        chk("rst.out_pc", out_pc, 32'h0);
        chk("rst.im_addr", im_addr, 32'h0);
        chk("rst.halted", {31'h0, halted}, 32'h0);
        chk("rst.fetch_cnt", {16'h0, fetch_cnt}, 32'h0);

        // streaming: boot cycle, then 0,8,16,24 back to back
        rst_n = 1'b1;
        tick();
        chk_all("boot", 1'b0, 32'h0, 32'h0, 16'd0);
        tick();
        chk_all("seq0", 1'b1, 32'h00, 32'h08, 16'd1);
        tick();
        chk_all("seq1", 1'b1, 32'h08, 32'h10, 16'd2);
        tick();
        chk_all("seq2", 1'b1, 32'h10, 32'h18, 16'd3);
        tick();
        chk_all("seq3", 1'b1, 32'h18, 32'h20, 16'd4);

        // back-pressure for 3 cycles: everything frozen
        out_ready = 1'b0;
        tick();
        chk_all("bp0", 1'b1, 32'h18, 32'h20, 16'd4);
        stall = 1'b1;  // stall together with !out_ready: pure hold
        tick();
        chk_all("bp1", 1'b1, 32'h18, 32'h20, 16'd4);
        stall = 1'b0;
        tick();
        chk_all("bp2", 1'b1, 32'h18, 32'h20, 16'd4);
        out_ready = 1'b1;
        tick();
        chk_all("bp_rel", 1'b1, 32'h20, 32'h28, 16'd5);

        // one-cycle stall: bubble of exactly one cycle
        stall = 1'b1;
        tick();
        chk_all("stall", 1'b0, 32'h0, 32'h28, 16'd5);
        stall = 1'b0;
        tick();
        chk_all("stall_rel", 1'b1, 32'h28, 32'h30, 16'd6);

        // redirect overrides stall while IF/ID holds a valid instruction
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stall          = 1'b1;
        tick();
        chk_all("redir", 1'b0, 32'h0, 32'h40, 16'd6);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tick();
        chk_all("redir_tgt", 1'b1, 32'h40, 32'h48, 16'd7);

        // halt word at 0x18
        halt_en        = 1'b1;
        halt_at        = 32'h18;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        chk_all("h_redir", 1'b0, 32'h0, 32'h10, 16'd7);
        redirect_valid = 1'b0;
        tick();
        chk_all("h_pre", 1'b1, 32'h10, 32'h18, 16'd8);
        tick();
        chk("h_word.out_instr", out_instr, HALT_WORD);
        chk("h_word.out_pc", out_pc, 32'h18);
        chk("h_word.out_valid", {31'h0, out_valid}, 32'h1);
        chk("h_word.halted", {31'h0, halted}, 32'h1);
        chk("h_word.im_addr", im_addr, 32'h20);
        chk("h_word.fetch_cnt", {16'h0, fetch_cnt}, 32'd9);
        halt_en = 1'b0;  // memory at 0x20 is ordinary; halt must still block fetch
        tick();
        chk("h1.halted", {31'h0, halted}, 32'h1);
        chk_all("h1", 1'b0, 32'h0, 32'h20, 16'd9);
        tick();
        chk_all("h2", 1'b0, 32'h0, 32'h20, 16'd9);

        // redirect out of halt to 0x0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        chk("unhalt.halted", {31'h0, halted}, 32'h0);
        chk_all("unhalt", 1'b0, 32'h0, 32'h0, 16'd9);
        redirect_valid = 1'b0;
        tick();
        chk_all("resume0", 1'b1, 32'h00, 32'h08, 16'd10);
        tick();
        chk_all("resume1", 1'b1, 32'h08, 32'h10, 16'd11);

        // asynchronous reset mid-stream, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst.out_pc", out_pc, 32'h0);
        chk("arst.out_instr", out_instr, 32'h0);
        chk("arst.im_addr", im_addr, 32'h0);
        chk("arst.fetch_cnt", {16'h0, fetch_cnt}, 32'h0);
        chk("arst.halted", {31'h0, halted}, 32'h0);

        // redirect during the boot cycle, then pc wrap at the top of memory
        tick();
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        chk_all("boot_redir", 1'b0, 32'h0, 32'hFFFF_FFF8, 16'd0);
        redirect_valid = 1'b0;
        tick();
        chk_all("wrap0", 1'b1, 32'hFFFF_FFF8, 32'h0, 16'd1);
        tick();
        chk_all("wrap1", 1'b1, 32'h0, 32'h8, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
